seg_scan_drv: RTL and testbench

Parametrised multiplexed seven-segment display driver: takes an N-digit hex value with per-digit decimal points and drives shared active-low cathodes plus N active-low anodes by time-division scanning. It adds inter-digit dead time, frame-synchronous tear-free value loading, leading-zero blanking and optional per-digit blinking. It sits between the board-level counter/datapath logic and the SEG/anode pins of the FPGA top.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg_scan_drv.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_drv.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions
// and active-low hex glyphs in {g,f,e,d,c,b,a} order.
package seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment pattern (no dp).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed N-digit seven-segment driver with dead time, frame-synchronous
// loading and leading-zero blanking; per-digit blinking built when SEG_BLINK_EN is defined.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_PERIOD  = 100_000,
  parameter int unsigned DEAD_CYCLES  = 0,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] VAL,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic                    LOAD,
  input  logic                    BLANK_LZ,
  input  logic [NUM_DIGITS-1:0]   BLINK,
  output logic [7:0]              SEG,
  output logic [NUM_DIGITS-1:0]   ANODE,
  output logic                    FRAME
);

  localparam int unsigned PW = $clog2(SCAN_PERIOD);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    run_q;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] hold_val_q, hold_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   hold_dp_q, hold_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_q, pend_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_q;
  logic                    tc, wrap, dead_d, lz_run;
  logic [NUM_DIGITS-1:0]   lz_mask, blink_mask;
  logic [6:0]              dec_seg;

  assign tc   = (pcnt_q == PW'(SCAN_PERIOD - 1));
  assign wrap = run_q && tc && (idx_q == IW'(NUM_DIGITS - 1));

  // Outputs are decoded from next-state values so SEG/ANODE land on the same edge as PCNT/IDX.
  always_comb begin
    pcnt_d     = '0;
    idx_d      = '0;
    if (run_q) begin
      pcnt_d = tc ? '0 : pcnt_q + PW'(1);
      idx_d  = idx_q;
      if (tc) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    hold_val_d = LOAD ? VAL : hold_val_q;
    hold_dp_d  = LOAD ? DP  : hold_dp_q;
    pend_d     = wrap ? 1'b0 : (LOAD ? 1'b1 : pend_q);
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (wrap && LOAD) begin
      disp_val_d = VAL;
      disp_dp_d  = DP;
    end else if (wrap && pend_q) begin
      disp_val_d = hold_val_q;
      disp_dp_d  = hold_dp_q;
    end
  end

  generate
    if (DEAD_CYCLES == 0) begin : g_nodead
      assign dead_d = 1'b0;
    end else begin : g_dead
      assign dead_d = (32'(pcnt_d) < DEAD_CYCLES);
    end
  endgenerate

  always_comb begin
    lz_mask = '0;
    lz_run  = BLANK_LZ;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (lz_run && disp_val_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0 && !disp_dp_d[NUM_DIGITS-1-k])
        lz_mask[NUM_DIGITS-1-k] = 1'b1;
      else
        lz_run = 1'b0;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  assign blink_mask = phase_d ? '0 : BLINK;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  localparam int unsigned UNUSED_BLINK_FRAMES = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = ^BLINK;
  assign blink_mask   = '0;
`endif

  seg7_decode u_dec (
    .hex_i (disp_val_d[4*int'(idx_d) +: 4]),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = SEG_OFF;
    if (!dead_d && !lz_mask[idx_d] && !blink_mask[idx_d]) begin
      seg_d[6:0]    = dec_seg;
      seg_d[SEG_DP] = ~disp_dp_d[idx_d];
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      anode_d[i] = dead_d || (32'(idx_d) != i);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      run_q      <= 1'b0;
      pcnt_q     <= '0;
      idx_q      <= '0;
      hold_val_q <= '0;
      hold_dp_q  <= '0;
      pend_q     <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SEG_OFF;
      anode_q    <= '1;
      frame_q    <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      hold_val_q <= hold_val_d;
      hold_dp_q  <= hold_dp_d;
      pend_q     <= pend_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      anode_q    <= anode_d;
      frame_q    <= wrap;
    end
  end

  assign SEG   = seg_q;
  assign ANODE = anode_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv: 4 digits, 4-cycle slots, 1 dead cycle, 2-frame blink.
module tb_seg_scan_drv;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] VAL = '0;
  logic [3:0]  DP = '0;
  logic        LOAD = 1'b0;
  logic        BLANK_LZ = 1'b0;
  logic [3:0]  BLINK = '0;
  logic [7:0]  SEG;
  logic [3:0]  ANODE;
  logic        FRAME;

  typedef struct packed {
    int          frame;
    logic [31:0] segs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   scyc = -2;

`ifdef SEG_BLINK_EN
  localparam logic [7:0] BLK = 8'hFF;
`else
  localparam logic [7:0] BLK = 8'hC0;
`endif

  seg_scan_drv #(
    .NUM_DIGITS   (4),
    .SCAN_PERIOD  (4),
    .DEAD_CYCLES  (1),
    .BLINK_FRAMES (2)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .VAL      (VAL),
    .DP       (DP),
    .LOAD     (LOAD),
    .BLANK_LZ (BLANK_LZ),
    .BLINK    (BLINK),
    .SEG      (SEG),
    .ANODE    (ANODE),
    .FRAME    (FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: tracks slot position from reset release on its own and checks every cycle.
  initial begin : monitor
    int         cyc;
    int         pc, id, fr;
    logic [3:0] an_exp;
    logic [7:0] cap [4];
    exp_t       e;
    cyc = -2;
    forever begin
      @(posedge CLK);
      if (!RST_N) cyc = -1;
      else if (cyc >= -1) cyc++;
      @(negedge CLK);
      if (cyc == -1) begin
        check("reset_anode", 32'(ANODE), 32'h0F);
        check("reset_seg", 32'(SEG), 32'hFF);
        check("reset_frame", 32'(FRAME), 32'h0);
      end else if (cyc >= 0) begin
        pc = cyc % 4;
        id = (cyc / 4) % 4;
        fr = cyc / 16;
        an_exp = (pc == 0) ? 4'hF : ~(4'b0001 << id);
        check($sformatf("anode c%0d", cyc), 32'(ANODE), 32'(an_exp));
        check($sformatf("frame c%0d", cyc), 32'(FRAME), 32'((cyc % 16 == 0) && (cyc > 0)));
        if (pc == 0) check($sformatf("dead_seg c%0d", cyc), 32'(SEG), 32'hFF);
        else if (pc == 1) cap[id] = SEG;
        if (cyc % 16 == 15) begin
          while (exp_q.size() > 0 && exp_q[0].frame < fr) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_frame: expectation for frame %0d not checked, now frame %0d", e.frame, fr);
          end
          if (exp_q.size() > 0 && exp_q[0].frame == fr) begin
            e = exp_q.pop_front();
            for (int d = 0; d < 4; d++)
              check($sformatf("f%0d_digit%0d_seg", fr, d), 32'(cap[d]), 32'(e.segs[8*d +: 8]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    scyc++;
  endtask

  task automatic goto(input int c);
    while (scyc < c) tick();
  endtask

  task automatic load_at(input int edge_c, input logic [15:0] v, input logic [3:0] d);
    goto(edge_c - 1);
    VAL  = v;
    DP   = d;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
  endtask

  task automatic push(input int f, input logic [7:0] s3, input logic [7:0] s2,
                      input logic [7:0] s1, input logic [7:0] s0);
    exp_t e;
    e.frame = f;
    e.segs  = {s3, s2, s1, s0};
    exp_q.push_back(e);
  endtask

  initial begin : stim
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    scyc  = -1;

    push(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    push(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    load_at(22, 16'h12AF, 4'b0100);
    push(2, 8'hF9, 8'h24, 8'h88, 8'h8E);
    push(3, 8'hF9, 8'h24, 8'h88, 8'h8E);
    load_at(50, 16'h1111, 4'b0000);
    load_at(58, 16'h2222, 4'b0000);
    push(4, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
    load_at(80, 16'h3456, 4'b0000);
    push(5, 8'hB0, 8'h99, 8'h92, 8'h82);
    goto(95);
    BLANK_LZ = 1'b1;
    load_at(96, 16'h0070, 4'b0000);
    push(6, 8'hFF, 8'hFF, 8'hF8, 8'hC0);
    load_at(112, 16'h0000, 4'b0000);
    push(7, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    load_at(128, 16'h0000, 4'b1000);
    push(8, 8'h40, 8'hC0, 8'hC0, 8'hC0);
    load_at(144, 16'h0000, 4'b0010);
    push(9, 8'hFF, 8'hFF, 8'h40, 8'hC0);

    // Pending load followed by a mid-slot reset: the pending value must never appear.
    load_at(165, 16'h9999, 4'b1111);
    goto(169);
    RST_N    = 1'b0;
    BLANK_LZ = 1'b0;
    BLINK    = 4'b0001;
    tick();
    tick();
    RST_N = 1'b1;
    scyc  = -1;

    push(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    push(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    push(2, 8'hC0, 8'hC0, 8'hC0, BLK);
    push(3, 8'hC0, 8'hC0, 8'hC0, BLK);
    push(4, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    goto(82);

    for (int n = 0; n < 100 && exp_q.size() > 0; n++) tick();
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
